// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and divisor floor for the SCL generator
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, LOW1, LOW2, HIGH1, HIGH2} state_e;
  localparam int DIV_MIN = 2;
endpackage

// File: rtl/i2c_sync2.sv
// i2c_sync2: two-flop synchronizer for the sensed SCL line, resets to the idle-high bus level
module i2c_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  // shift the asynchronous level through two flops
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      q_o    <= 1'b1;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end
endmodule

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: quarter-period SCL generator with phase strobes; define I2C_CLK_STRETCH_EN for clock stretching in HIGH1
import i2c_pkg::*;
module i2c_scl_gen #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 250
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             scl_in,
  output logic             i2c_clk,
  output logic             tick_fall,
  output logic             tick_mid_low,
  output logic             tick_rise,
  output logic             tick_mid_high,
  output logic             busy,
  output logic             stretched
);
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] QMIN = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] QRST = DIV_W'(DEFAULT_DIV);
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, q_q, q_d;
  logic             clk_d, fall_d, mid_low_d, rise_d, mid_high_d;
  logic             hold;
`ifdef I2C_CLK_STRETCH_EN
  logic scl_s;
  i2c_sync2 u_sync (.clk(ref_clk), .rst(reset), .d_i(scl_in), .q_o(scl_s));
  assign hold = (state_q == HIGH1) && !scl_s;
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign hold       = 1'b0;
`endif
  assign busy      = state_q != IDLE;
  assign stretched = hold;
  // state, phase counter, quarter register and registered outputs
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      q_q           <= QRST;
      i2c_clk       <= 1'b1;
      tick_fall     <= 1'b0;
      tick_mid_low  <= 1'b0;
      tick_rise     <= 1'b0;
      tick_mid_high <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      q_q           <= q_d;
      i2c_clk       <= clk_d;
      tick_fall     <= fall_d;
      tick_mid_low  <= mid_low_d;
      tick_rise     <= rise_d;
      tick_mid_high <= mid_high_d;
    end
  end
  // advance one phase every q cycles; loads accepted only while idle, clamped to the floor
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    q_d     = q_q;
    if (state_q == IDLE) begin
      cnt_d   = '0;
      q_d     = div_load ? (div_value < QMIN ? QMIN : div_value) : q_q;
      state_d = enable ? LOW1 : IDLE;
    end else if (hold) begin
      cnt_d = '0;
    end else if (cnt_q == q_q - ONE) begin
      cnt_d   = '0;
      state_d = state_q == LOW1  ? LOW2  :
                state_q == LOW2  ? HIGH1 :
                state_q == HIGH1 ? HIGH2 :
                enable           ? LOW1  : IDLE;
    end
  end
  // strobes mark the entry edge of each phase, aligned with the registered SCL level
  always_comb begin
    clk_d      = !(state_d == LOW1 || state_d == LOW2);
    fall_d     = state_d == LOW1  && state_q != LOW1;
    mid_low_d  = state_d == LOW2  && state_q == LOW1;
    rise_d     = state_d == HIGH1 && state_q == LOW2;
    mid_high_d = state_d == HIGH2 && state_q == HIGH1;
  end
endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: directed table-driven checks of SCL timing, divisor loading, enable drop and reset abort
module tb_i2c_scl_gen;
  logic        ref_clk = 1'b0;
  logic        reset, enable, div_load, scl_in;
  logic [15:0] div_value;
  logic        i2c_clk, tick_fall, tick_mid_low, tick_rise, tick_mid_high, busy, stretched;
  int          errors = 0;
  int          checks = 0;
  int          multi  = 0;

  typedef struct {
    bit          do_load;
    bit          with_en;
    logic [15:0] div;
    bit          busy_load;
    int          exp_q;
  } vec_t;
  vec_t vecs[8];

  i2c_scl_gen dut (
    .ref_clk(ref_clk), .reset(reset), .enable(enable), .div_load(div_load),
    .div_value(div_value), .scl_in(scl_in), .i2c_clk(i2c_clk), .tick_fall(tick_fall),
    .tick_mid_low(tick_mid_low), .tick_rise(tick_rise), .tick_mid_high(tick_mid_high),
    .busy(busy), .stretched(stretched)
  );

  always #5 ref_clk = ~ref_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ref_clk);
    #1;
    if (int'(tick_fall) + int'(tick_mid_low) + int'(tick_rise) + int'(tick_mid_high) > 1) multi++;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_clk"}, int'(i2c_clk), 1);
  endtask

  task automatic run_period(input int q, input bit busy_load, input string tag);
    int t_f1 = -1, t_ml = -1, t_r = -1, t_mh = -1, t_f2 = -1, lows = 0, highs = 0;
    enable = 1'b1;
    for (int t = 1; t <= 4 * q + 1; t++) begin
      step();
      div_load = 1'b0;
      if (tick_fall && t == 1) t_f1 = t;
      if (tick_fall && t > 1 && t_f2 < 0) t_f2 = t;
      if (tick_mid_low && t_ml < 0) t_ml = t;
      if (tick_rise && t_r < 0) t_r = t;
      if (tick_mid_high && t_mh < 0) t_mh = t;
      if (t <= 2 * q) lows += int'(!i2c_clk);
      else if (t <= 4 * q) highs += int'(i2c_clk);
      if (busy_load && t == 5) begin
        div_load  = 1'b1;
        div_value = 16'd10;
      end
    end
    enable = 1'b0;
    chk({tag, "_fall"}, t_f1, 1);
    chk({tag, "_mid_low"}, t_ml, 1 + q);
    chk({tag, "_rise"}, t_r, 1 + 2 * q);
    chk({tag, "_mid_high"}, t_mh, 1 + 3 * q);
    chk({tag, "_next_fall"}, t_f2, 1 + 4 * q);
    chk({tag, "_low_cycles"}, lows, 2 * q);
    chk({tag, "_high_cycles"}, highs, 2 * q);
    wait_idle(4 * q + 4, tag);
  endtask

  initial begin
    vecs = '{
      '{0, 0, 16'd0,   0, 250},
      '{1, 0, 16'd1,   0, 2},
      '{1, 1, 16'd0,   0, 2},
      '{1, 0, 16'd3,   0, 3},
      '{1, 1, 16'd10,  0, 10},
      '{1, 0, 16'd250, 0, 250},
      '{0, 0, 16'd0,   1, 250},
      '{1, 0, 16'd10,  0, 10}
    };
`ifdef I2C_CLK_STRETCH_EN
    scl_in = 1'b1;
`else
    scl_in = 1'b0;
`endif
    reset     = 1'b1;
    enable    = 1'b0;
    div_load  = 1'b1;
    div_value = 16'd5;
    step();
    step();
    div_load = 1'b0;
    chk("rst_clk", int'(i2c_clk), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobes", int'(tick_fall) + int'(tick_mid_low) + int'(tick_rise) + int'(tick_mid_high), 0);
    chk("rst_stretched", int'(stretched), 0);
    reset = 1'b0;
    step();
    chk("idle_clk", int'(i2c_clk), 1);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_load) begin
        div_load  = 1'b1;
        div_value = vecs[i].div;
        if (!vecs[i].with_en) begin
          step();
          div_load = 1'b0;
        end
      end
      run_period(vecs[i].exp_q, vecs[i].busy_load, $sformatf("vec%0d", i));
    end

    begin
      int q = 10, falls = 0, lows = 0, t_mh = -1, busy_end = -1, busy_last = -1;
      enable = 1'b1;
      for (int t = 1; t <= 4 * q + 3; t++) begin
        step();
        if (tick_fall && t > 1) falls++;
        if (tick_mid_high && t_mh < 0) t_mh = t;
        if (t > 2 * q) lows += int'(!i2c_clk);
        if (t == 4 * q) busy_last = int'(busy);
        if (t == 4 * q + 1) busy_end = int'(busy);
        if (t == q + 3) enable = 1'b0;
      end
      chk("drop_extra_fall", falls, 0);
      chk("drop_mid_high", t_mh, 1 + 3 * q);
      chk("drop_high_kept", lows, 0);
      chk("drop_busy_last", busy_last, 1);
      chk("drop_busy_end", busy_end, 0);
      chk("drop_clk_idle", int'(i2c_clk), 1);
    end

    div_load  = 1'b1;
    div_value = 16'd250;
    step();
    div_load = 1'b0;
    enable   = 1'b1;
    for (int t = 1; t <= 2 * 250 + 5; t++) step();
    chk("hi1_in_high", int'(i2c_clk), 1);
    reset = 1'b1;
    step();
    chk("hi1_rst_busy", int'(busy), 0);
    chk("hi1_rst_clk", int'(i2c_clk), 1);
    chk("hi1_rst_strobes", int'(tick_fall) + int'(tick_mid_low) + int'(tick_rise) + int'(tick_mid_high), 0);
    reset  = 1'b0;
    enable = 1'b0;
    step();
    chk("hi1_after_busy", int'(busy), 0);
    run_period(250, 1'b0, "hi1_q");

    div_load  = 1'b1;
    div_value = 16'd7;
    step();
    div_load = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    run_period(250, 1'b0, "rst_q");

`ifdef I2C_CLK_STRETCH_EN
    begin
      int q = 250, st = 0, t_mh = -1, t_f2 = -1, t_r = -1, hold_end = -1;
      enable = 1'b1;
      for (int t = 1; t <= 4 * q + 200; t++) begin
        step();
        st += int'(stretched);
        if (tick_rise && t_r < 0) begin
          t_r      = t;
          scl_in   = 1'b0;
          hold_end = t + 100;
        end
        if (t == hold_end) scl_in = 1'b1;
        if (tick_mid_high && t_mh < 0) t_mh = t;
        if (tick_fall && t > 1 && t_f2 < 0) t_f2 = t;
        if (t_f2 > 0) enable = 1'b0;
      end
      chk("str_rise", t_r, 1 + 2 * q);
      chk("str_count_range", int'(st >= 99 && st <= 104), 1);
      chk("str_mid_high_delay", int'(t_mh - (1 + 3 * q) >= st && t_mh - (1 + 3 * q) <= st + 3), 1);
      chk("str_period_range", int'(t_f2 - 1 >= 4 * q + 99 && t_f2 - 1 <= 4 * q + 107), 1);
      wait_idle(4 * q + 4, "str");
    end
`endif

    chk("one_strobe_per_cycle", multi, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_scl_gen.md
I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the quarter-period divisor.
REQ-002 SHALL have parameter DEFAULT_DIV, default 250, quarter-period in ref_clk cycles after reset (100 MHz / (4*250) = 100 kHz).
REQ-003 SHALL have port ref_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port enable, input, 1, request SCL toggling.
REQ-006 SHALL have port div_load, input, 1, load div_value into the quarter-period register.
REQ-007 SHALL have port div_value, input, DIV_W, new quarter-period count.
REQ-008 SHALL have port scl_in, input, 1, sensed bus SCL level, used only with the stretch feature.
REQ-009 SHALL have port i2c_clk, output, 1, generated SCL level.
REQ-010 SHALL have ports tick_fall, tick_mid_low, tick_rise and tick_mid_high, each output, 1, a one-cycle strobe.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 SHALL have port stretched, output, 1, high while a stretch hold is active.

Function
REQ-013 SHALL implement states IDLE, LOW1, LOW2, HIGH1 and HIGH2.
REQ-014 SHALL hold each non-IDLE state for exactly q cycles, q being the quarter register: phase counter runs 0..q-1, then the state advances and the counter clears.
REQ-015 SHALL drive i2c_clk=1 in IDLE, HIGH1 and HIGH2, and i2c_clk=0 in LOW1 and LOW2, all registered.
REQ-016 SHALL, in IDLE with enable=1, go to LOW1 next cycle and pulse tick_fall in that same cycle.
REQ-017 SHALL pulse tick_mid_low on LOW1->LOW2 (data-change point).
REQ-018 SHALL pulse tick_rise on LOW2->HIGH1.
REQ-019 SHALL pulse tick_mid_high on HIGH1->HIGH2 (sample point).
REQ-020 SHALL, at the end of HIGH2, go to LOW1 with tick_fall if enable=1, else to IDLE with no strobe.
REQ-021 SHALL, when enable is deasserted mid-period, complete the period to the end of HIGH2; SCL is never truncated.
REQ-022 SHALL make each strobe coincident with the cycle whose registered i2c_clk first shows the new phase; at most one strobe fires per cycle.
REQ-023 SHALL honour div_load only in IDLE; it is ignored when busy=1.
REQ-024 SHALL clamp a loaded value below 2 to 2.
REQ-025 SHALL give priority to enable over a simultaneous div_load in IDLE: the load takes effect and the first period uses the new q.
REQ-026 SHALL give a full SCL period of exactly 4*q cycles, with a 50% duty when there is no stretch.

Reset
REQ-027 SHALL, when reset=1, set state=IDLE, counter=0, q=DEFAULT_DIV, i2c_clk=1, all strobes=0, busy=0 and stretched=0 on the next edge.
REQ-028 SHALL give reset priority over enable and div_load; reset mid-period aborts immediately with no tick_fall.

Configuration
REQ-029 SHALL, with macro I2C_CLK_STRETCH_EN defined, pass scl_in through a 2-flop synchronizer.
REQ-030 SHALL, with I2C_CLK_STRETCH_EN defined, hold the HIGH1 counter at 0 while the synchronized SCL is 0, with stretched=1 during the hold; counting resumes on the first cycle it reads 1.
REQ-031 SHALL, with I2C_CLK_STRETCH_EN defined, not stretch LOW phases or HIGH2.
REQ-032 SHALL, with I2C_CLK_STRETCH_EN undefined, ignore scl_in, tie stretched to 0 and omit the synchronizer flops.

Structure
REQ-033 SHALL place the state enum and constant DIV_MIN=2 in shared package i2c_pkg.
REQ-034 SHALL implement the synchronizer as sub-module i2c_sync2, instantiated only under I2C_CLK_STRETCH_EN.

Verification
REQ-035 SHALL cover reset then enable=1 with q=250: tick_fall at cycle 1, tick_mid_low at 251, tick_rise at 501, tick_mid_high at 751, next tick_fall at 1001; i2c_clk low for 500 cycles and high for 500.
REQ-036 SHALL cover div_load=1 with div_value=1 in IDLE, then enable: q clamps to 2 and the period is 8 cycles.
REQ-037 SHALL cover div_load=1 with div_value=10 while busy: it is ignored and the period stays 1000; after return to IDLE, the same load gives a 40-cycle period.
REQ-038 SHALL cover enable dropped in LOW2: the period completes through HIGH2, busy falls, there is no extra tick_fall and i2c_clk stays 1.
REQ-039 SHALL cover reset asserted in HIGH1 at q=250: next cycle IDLE, i2c_clk=1, q=250 and no strobes.
REQ-040 SHALL cover, with I2C_CLK_STRETCH_EN, scl_in held 0 for 100 cycles after tick_rise: stretched=1 for about 102 cycles, tick_mid_high is delayed by the same amount, and the period is about 1102.
